// File: rtl/amstrad_mem_pkg.sv
// Shared constants for the Amstrad external RAM arbitration path.
package amstrad_mem_pkg;

  // External RAM address width as produced by the MMU mapping.
  localparam int RAM_AW = 23;

  // Transaction owner encoding.
  localparam logic [1:0] OWN_VID = 2'd0;
  localparam logic [1:0] OWN_CPU = 2'd1;
  localparam logic [1:0] OWN_LD  = 2'd2;

  // Arbiter states.
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  // Convert a one-hot grant {ld, cpu, vid} into an owner code.
  function automatic logic [1:0] grant_owner(input logic [2:0] grant);
    if (grant[0]) return OWN_VID;
    if (grant[1]) return OWN_CPU;
    return OWN_LD;
  endfunction

endpackage

// File: rtl/amstrad_prio_sel.sv
// Combinational winner selection: video first, then CPU, then loader,
// except that a starved loader overtakes the CPU.
module amstrad_prio_sel (
  input  logic       vid_req,
  input  logic       cpu_req,
  input  logic       ld_req,
  input  logic       starve_flag,
  output logic [2:0] grant        // one-hot {ld, cpu, vid}
);

  // Fixed-priority pick with the loader anti-starvation override.
  always_comb begin
    grant = 3'b000;
    if (vid_req) begin
      grant = 3'b001;
    end else if (cpu_req && !(ld_req && starve_flag)) begin
      grant = 3'b010;
    end else if (ld_req) begin
      grant = 3'b100;
    end
  end

endmodule

// File: rtl/amstrad_ram_arbiter.sv
// Single-outstanding arbiter sharing the external RAM port between video
// fetch, the Z80 CPU and the ROM/disk image loader, with a watchdog that
// recovers from a lost memory acknowledge.
module amstrad_ram_arbiter
  import amstrad_mem_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 63,
  parameter int AW         = RAM_AW
) (
  input  logic          CLK,
  input  logic          reset_n,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic [7:0]    vid_dout,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic          cpu_ack,
  output logic [7:0]    cpu_dout,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_din,
  output logic          ld_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_din,
  input  logic          mem_ack,
  input  logic [7:0]    mem_dout,
  output logic          timeout_err
);

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);
  localparam logic [5:0] WD_LIM     = 6'(TIMEOUT);

  logic          state_reg;
  logic [1:0]    owner_reg;
  logic [2:0]    starve_cnt_reg;
  logic [5:0]    wd_cnt_reg;
  logic [2:0]    grant;
  logic          any_req;
  logic          decide;
  logic          starve_flag;
  logic          done;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [7:0]    sel_din;

  assign any_req     = vid_req | cpu_req | ld_req;
  assign decide      = (state_reg == ST_IDLE) && any_req;
  assign starve_flag = (starve_cnt_reg == STARVE_LIM);

  amstrad_prio_sel u_prio_sel (
    .vid_req     (vid_req),
    .cpu_req     (cpu_req),
    .ld_req      (ld_req),
    .starve_flag (starve_flag),
    .grant       (grant)
  );

  // Completion is only honoured in BUSY; a stray mem_ack in IDLE is dropped.
  assign done    = (state_reg == ST_BUSY) && mem_ack;
  assign vid_ack = done && (owner_reg == OWN_VID);
  assign cpu_ack = done && (owner_reg == OWN_CPU);
  assign ld_ack  = done && (owner_reg == OWN_LD);

  // Route the winner's command fields; video is always a read.
  always_comb begin
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_din  = 8'h00;
    if (grant[0]) begin
      sel_addr = vid_addr;
    end else if (grant[1]) begin
      sel_we   = cpu_we;
      sel_addr = cpu_addr;
      sel_din  = cpu_din;
    end else if (grant[2]) begin
      sel_we   = ld_we;
      sel_addr = ld_addr;
      sel_din  = ld_din;
    end
  end

  // IDLE/BUSY sequencing, command latch, one-cycle mem_req and watchdog.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= ST_IDLE;
      owner_reg   <= OWN_VID;
      wd_cnt_reg  <= 6'd0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_din     <= 8'h00;
      timeout_err <= 1'b0;
    end else begin
      mem_req <= 1'b0;
      if (state_reg == ST_IDLE) begin
        if (any_req) begin
          mem_req    <= 1'b1;
          mem_we     <= sel_we;
          mem_addr   <= sel_addr;
          mem_din    <= sel_din;
          owner_reg  <= grant_owner(grant);
          wd_cnt_reg <= 6'd0;
          state_reg  <= ST_BUSY;
        end
      end else begin
        if (mem_ack) begin
          state_reg <= ST_IDLE;
        end else if (wd_cnt_reg == WD_LIM) begin
          // Lost acknowledge: abandon silently; the requester retries.
          state_reg   <= ST_IDLE;
          timeout_err <= 1'b1;
        end else begin
          wd_cnt_reg <= wd_cnt_reg + 6'd1;
        end
      end
    end
  end

  // Capture read data for the owner on completion; held until its next read.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      vid_dout <= 8'h00;
      cpu_dout <= 8'h00;
    end else if (done) begin
      if (owner_reg == OWN_VID) vid_dout <= mem_dout;
      if ((owner_reg == OWN_CPU) && !mem_we) cpu_dout <= mem_dout;
    end
  end

  // Count CPU wins while the loader waits; any loader idle cycle or win resets it.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt_reg <= 3'd0;
    end else if (!ld_req) begin
      starve_cnt_reg <= 3'd0;
    end else if (decide && grant[2]) begin
      starve_cnt_reg <= 3'd0;
    end else if (decide && grant[1] && !starve_flag) begin
      starve_cnt_reg <= starve_cnt_reg + 3'd1;
    end
  end

endmodule

// File: tb/tb_amstrad_ram_arbiter.sv
// Self-checking bench for amstrad_ram_arbiter: transaction-level reference
// model plus directed scenarios and a randomized traffic phase.
module tb_amstrad_ram_arbiter;

  localparam int AW         = 23;
  localparam int TIMEOUT    = 63;
  localparam int STARVE_MAX = 4;

  logic          CLK = 1'b0;
  logic          reset_n = 1'b0;
  logic          vid_req = 1'b0, cpu_req = 1'b0, ld_req = 1'b0;
  logic [AW-1:0] vid_addr = '0, cpu_addr = '0, ld_addr = '0;
  logic          cpu_we = 1'b0, ld_we = 1'b0;
  logic [7:0]    cpu_din = 8'h00, ld_din = 8'h00;
  logic          vid_ack, cpu_ack, ld_ack;
  logic [7:0]    vid_dout, cpu_dout;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic          mem_ack = 1'b0;
  logic [7:0]    mem_dout = 8'h00;
  logic          timeout_err;

  always #5 CLK = ~CLK;

  amstrad_ram_arbiter dut (
    .CLK(CLK), .reset_n(reset_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_dout(vid_dout),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_din(ld_din), .ld_ack(ld_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_ack(mem_ack), .mem_dout(mem_dout), .timeout_err(timeout_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requesters (0 = video, 1 = cpu, 2 = loader)
  bit            act[3];
  bit            hold[3];
  bit            acked[3];
  logic [AW-1:0] r_addr[3];
  bit            r_we[3];
  logic [7:0]    r_din[3];
  int            raise_pct = 0;

  // Reference model
  bit            outst = 0;
  int            owner_m = 0;
  bit            own_we_m = 0;
  int            age = 0;
  bit            exp_dec = 0;
  int            dec_win = 0;
  logic [AW-1:0] dec_addr = '0;
  bit            dec_we = 0;
  logic [7:0]    dec_din = 8'h00;
  int            starve_m = 0;
  bit            terr_m = 0;
  logic [7:0]    vdout_m = 8'h00, cdout_m = 8'h00;
  int            mreq_cnt = 0;
  int            ack_log[$];

  // Memory controller model
  bit            resp_pend = 0;
  int            resp_lat = 0;
  logic [7:0]    resp_data = 8'h00;
  int            withhold = 0;
  int            wd_pct = 0;
  int            lat_min = 0, lat_max = 0;
  bit            stray_ok = 0;
  int            stray_pct = 0;
  bit            force_ack = 0;
  logic [7:0]    mem_m [int];

  function automatic logic [7:0] mem_read(input logic [AW-1:0] a);
    if (mem_m.exists(int'(a))) return mem_m[int'(a)];
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  task automatic apply_reqs();
    vid_req = act[0]; vid_addr = r_addr[0];
    cpu_req = act[1]; cpu_addr = r_addr[1]; cpu_we = r_we[1]; cpu_din = r_din[1];
    ld_req  = act[2]; ld_addr  = r_addr[2]; ld_we  = r_we[2]; ld_din  = r_din[2];
  endtask

  task automatic start_req(input int i, input logic [AW-1:0] a, input bit we, input logic [7:0] d);
    act[i] = 1; r_addr[i] = a; r_we[i] = (i == 0) ? 1'b0 : we; r_din[i] = d;
    apply_reqs();
  endtask

  task automatic new_txn(input int i);
    start_req(i, AW'($urandom), 1'($urandom), 8'($urandom));
  endtask

  task automatic model_reset();
    outst = 0; exp_dec = 0; starve_m = 0; terr_m = 0; vdout_m = 8'h00; cdout_m = 8'h00;
    resp_pend = 0; withhold = 0; stray_ok = 0; force_ack = 0; mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin act[i] = 0; acked[i] = 0; hold[i] = 0; end
    apply_reqs();
  endtask

  // Observe one cycle (called at negedge) and update the reference model.
  task automatic monitor();
    logic [2:0] exp_ack;
    int         win;
    bit         idle;
    bit         any;
    bit         hold_back;
    check_val("vid_dout", 32'(vid_dout), 32'(vdout_m));
    check_val("cpu_dout", 32'(cpu_dout), 32'(cdout_m));
    check_val("mem_req", 32'(mem_req), 32'(exp_dec));
    if (exp_dec) begin
      mreq_cnt++;
      check_val("mem_addr", 32'(mem_addr), 32'(dec_addr));
      check_val("mem_we", 32'(mem_we), 32'(dec_we));
      if (dec_we) check_val("mem_din", 32'(mem_din), 32'(dec_din));
      outst = 1; owner_m = dec_win; own_we_m = dec_we; age = 0;
      if (dec_we) mem_m[int'(dec_addr)] = dec_din;
      hold_back = (withhold > 0) || (int'($urandom_range(0, 99)) < wd_pct);
      if (withhold > 0) withhold--;
      if (!hold_back) begin
        resp_pend = 1;
        resp_lat  = int'($urandom_range(lat_min, lat_max));
        resp_data = dec_we ? 8'($urandom) : mem_read(dec_addr);
      end
    end else if (outst) begin
      age++;
      // BUSY lasts watchdog counts 0..TIMEOUT; the cycle after that is IDLE.
      if (age == TIMEOUT + 1) begin outst = 0; terr_m = 1; end
    end
    check_val("timeout_err", 32'(timeout_err), 32'(terr_m));
    idle = !outst;
    exp_ack = 3'b000;
    if (outst && mem_ack) begin
      exp_ack[owner_m] = 1'b1;
      outst = 0;
      acked[owner_m] = 1;
      if (owner_m == 0) vdout_m = mem_dout;
      else if (owner_m == 1 && !own_we_m) cdout_m = mem_dout;
    end
    check_val("acks", 32'({ld_ack, cpu_ack, vid_ack}), 32'(exp_ack));
    if (vid_ack) ack_log.push_back(0);
    if (cpu_ack) ack_log.push_back(1);
    if (ld_ack)  ack_log.push_back(2);
    any = vid_req || cpu_req || ld_req;
    if (!ld_req) starve_m = 0;
    exp_dec = 0;
    if (idle && reset_n && any) begin
      if (vid_req) win = 0;
      else if (ld_req && starve_m >= STARVE_MAX) win = 2;
      else if (cpu_req) win = 1;
      else win = 2;
      if (win == 1 && ld_req && starve_m < STARVE_MAX) starve_m++;
      if (win == 2) starve_m = 0;
      dec_win  = win;
      dec_addr = (win == 0) ? vid_addr : (win == 1) ? cpu_addr : ld_addr;
      dec_we   = (win == 0) ? 1'b0 : (win == 1) ? cpu_we : ld_we;
      dec_din  = (win == 1) ? cpu_din : ld_din;
      exp_dec  = 1;
    end
    stray_ok = !outst && !any;
  endtask

  // Drive inputs for the next cycle (called just after posedge).
  task automatic drive();
    mem_ack = 1'b0;
    if (resp_pend) begin
      if (resp_lat == 0) begin mem_ack = 1'b1; mem_dout = resp_data; resp_pend = 0; end
      else resp_lat--;
    end else if (force_ack || (stray_ok && int'($urandom_range(0, 99)) < stray_pct)) begin
      mem_ack = 1'b1; mem_dout = 8'($urandom); force_ack = 0;
    end
    for (int i = 0; i < 3; i++) begin
      if (acked[i]) begin
        acked[i] = 0;
        if (hold[i]) new_txn(i); else act[i] = 0;
      end else if (!act[i] && int'($urandom_range(0, 99)) < raise_pct) begin
        new_txn(i);
      end
    end
    apply_reqs();
  endtask

  task automatic cycle();
    @(negedge CLK); monitor();
    @(posedge CLK); #1; drive();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((act[0] || act[1] || act[2] || outst || resp_pend || exp_dec) && n < 2000) begin
      cycle(); n++;
    end
    if (n >= 2000) check_val(tag, 32'd1, 32'd0);
    cycle();
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int n;
    model_reset();
    repeat (3) @(posedge CLK);
    #1 reset_n = 1'b1;
    repeat (2) cycle();
    check_val("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_val("rst_mem_we", 32'(mem_we), 32'd0);
    check_val("rst_mem_din", 32'(mem_din), 32'd0);

    // CPU read alone, ack three cycles after mem_req
    mem_m[int'(23'h0C123)] = 8'h5A;
    lat_min = 2; lat_max = 2; mreq_cnt = 0; ack_log.delete();
    start_req(1, 23'h0C123, 1'b0, 8'h00);
    wait_idle("cpu_read_done");
    check_val("cpu_read_mreq_cnt", 32'(mreq_cnt), 32'd1);
    check_val("cpu_read_dout", 32'(cpu_dout), 32'h5A);
    check_val("cpu_read_acks", 32'(ack_log.size()), 32'd1);
    repeat (3) cycle();
    check_val("cpu_read_dout_held", 32'(cpu_dout), 32'h5A);

    // Three-way contention
    lat_min = 0; lat_max = 3; ack_log.delete();
    start_req(0, 23'h00400, 1'b0, 8'h00);
    start_req(1, 23'h02222, 1'b0, 8'h00);
    start_req(2, 23'h01234, 1'b1, 8'hA7);
    wait_idle("contention_done");
    check_val("contention_cnt", 32'(ack_log.size()), 32'd3);
    for (int i = 0; i < 3 && i < ack_log.size(); i++)
      check_val("contention_order", 32'(ack_log[i]), 32'(i));

    // Loader starvation with the CPU held continuously
    ack_log.delete(); hold[1] = 1;
    start_req(1, 23'h03000, 1'b0, 8'h00);
    start_req(2, 23'h04000, 1'b1, 8'h11);
    n = 0;
    while (ack_log.size() < 6 && n < 1000) begin cycle(); n++; end
    hold[1] = 0;
    wait_idle("starve_done");
    check_val("starve_cnt", 32'(ack_log.size() >= 6), 32'd1);
    for (int i = 0; i < 6 && i < ack_log.size(); i++)
      check_val("starve_order", 32'(ack_log[i]), (i == 4) ? 32'd2 : 32'd1);

    // Watchdog: first mem_ack withheld
    ack_log.delete(); mreq_cnt = 0; withhold = 1;
    start_req(1, 23'h05555, 1'b0, 8'h00);
    wait_idle("watchdog_done");
    check_val("watchdog_err", 32'(timeout_err), 32'd1);
    check_val("watchdog_mreq_cnt", 32'(mreq_cnt), 32'd2);
    check_val("watchdog_acks", 32'(ack_log.size()), 32'd1);

    // Asynchronous reset in the middle of a loader transaction
    ack_log.delete(); withhold = 1;
    start_req(2, 23'h06060, 1'b1, 8'h3C);
    n = 0;
    while (!outst && n < 20) begin cycle(); n++; end
    repeat (3) cycle();
    check_val("rst_mid_busy_pending", 32'(outst), 32'd1);
    #2 reset_n = 1'b0; mem_ack = 1'b1;
    #1;
    check_val("rst_async_mem_req", 32'(mem_req), 32'd0);
    check_val("rst_async_mem_we", 32'(mem_we), 32'd0);
    check_val("rst_async_mem_addr", 32'(mem_addr), 32'd0);
    check_val("rst_async_mem_din", 32'(mem_din), 32'd0);
    check_val("rst_async_ld_ack", 32'(ld_ack), 32'd0);
    check_val("rst_async_timeout_err", 32'(timeout_err), 32'd0);
    check_val("rst_async_vid_dout", 32'(vid_dout), 32'd0);
    model_reset();
    repeat (2) cycle();
    reset_n = 1'b1;
    cycle();
    force_ack = 1;
    repeat (3) cycle();
    check_val("late_ack_no_ld_ack", 32'(ack_log.size()), 32'd0);

    // Stray mem_ack in IDLE, then normal operation
    mreq_cnt = 0;
    force_ack = 1;
    repeat (3) cycle();
    check_val("stray_acks", 32'(ack_log.size()), 32'd0);
    check_val("stray_mreq", 32'(mreq_cnt), 32'd0);
    start_req(1, 23'h07070, 1'b1, 8'hC3);
    wait_idle("after_stray_done");
    check_val("after_stray_acks", 32'(ack_log.size()), 32'd1);

    // Randomized traffic
    raise_pct = 25; stray_pct = 20; wd_pct = 2; lat_min = 0; lat_max = 3;
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) hold[1] = 1'($urandom);
      cycle();
    end
    raise_pct = 0; stray_pct = 0; wd_pct = 0; hold[1] = 0;
    wait_idle("random_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
